// File: rtl/fpu_ctrl.sv
// fpu_ctrl: sequencer/arbiter between the MIX CPU and the floating-point units
// (FADD, FSUB, FMUL, FDIV). One command is in flight at a time: it is accepted
// in IDLE, a one-cycle start pulse goes to the selected unit in ISSUE, the
// controller waits for that unit's stop (or a timeout) in WAIT, and it holds
// the result in DONE until the CPU takes it.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_op selects the unit, cmd_in1/2 operands
//   res_valid/res_ready   result handshake; res_out, res_ovf, res_err
//   u_start               one-hot start pulse to the units
//   u_in1, u_in2          shared operand buses, held from the accepting register
//   u_stop, u_ovf         per-unit completion pulse and overflow flag
//   u_out                 concatenated unit results, unit i on [31*i+30:31*i]
module fpu_ctrl #(
  parameter int NUNITS  = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [2:0]             cmd_op,
  input  logic [30:0]            cmd_in1,
  input  logic [30:0]            cmd_in2,
  output logic                   cmd_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [30:0]            res_out,
  output logic                   res_ovf,
  output logic                   res_err,
  output logic [NUNITS-1:0]      u_start,
  output logic [30:0]            u_in1,
  output logic [30:0]            u_in2,
  input  logic [NUNITS-1:0]      u_stop,
  input  logic [31*NUNITS-1:0]   u_out,
  input  logic [NUNITS-1:0]      u_ovf
);

  localparam int DATA_W = 31;
  localparam int OP_W   = 3;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [OP_W-1:0]     op_r;
  logic [CNT_W-1:0]    cnt;

  logic                op_legal;
  logic                sel_stop;
  logic                sel_ovf;
  logic [DATA_W-1:0]   sel_out;

  // One-hot start vector for a (legal) unit number.
  function automatic logic [NUNITS-1:0] onehot(input logic [OP_W-1:0] op);
    logic [NUNITS-1:0] v;
    v = '0;
    for (int i = 0; i < NUNITS; i++) begin
      if (op == OP_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign op_legal = ({29'd0, cmd_op} < 32'(NUNITS));

  // Only the unit serving the latched op is observed; every other unit's
  // stop/ovf/result is masked out here.
  always_comb begin
    sel_stop = 1'b0;
    sel_ovf  = 1'b0;
    sel_out  = '0;
    for (int i = 0; i < NUNITS; i++) begin
      if (op_r == OP_W'(i)) begin
        sel_stop = u_stop[i];
        sel_ovf  = u_ovf[i];
        sel_out  = u_out[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_r      <= '0;
      cnt       <= '0;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      res_out   <= '0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b0;
      u_start   <= '0;
      u_in1     <= '0;
      u_in2     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_r      <= cmd_op;
            u_in1     <= cmd_in1;
            u_in2     <= cmd_in2;
            res_ovf   <= 1'b0;
            res_err   <= 1'b0;
            cmd_ready <= 1'b0;
            if (op_legal) begin
              // Start is registered here so it is high exactly during ISSUE.
              u_start <= onehot(cmd_op);
              state   <= ISSUE;
            end else begin
              res_err   <= 1'b1;
              res_out   <= '0;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ISSUE: begin
          u_start <= '0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // Stop is tested first so a stop on the timeout cycle still wins.
          if (sel_stop) begin
            res_out   <= sel_out;
            res_ovf   <= sel_ovf;
            res_valid <= 1'b1;
            state     <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            res_err   <= 1'b1;
            res_out   <= '0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
